// File: rtl/countdown_timer_n.sv
// Programmable countdown timer with prescaler, load/start/pause control,
// one-shot or auto-reload operation and a registered terminal-count pulse.
module countdown_timer_n #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] div,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             expired
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick_s;

  // A reduced div still ticks at once because the compare is >=, never ==.
  assign tick_s = (pre_q >= div);

  // Next-state logic: load beats pause, pause beats start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (load) begin
      rld_d   = D;
      cnt_d   = D;
      pre_d   = {PRE_W{1'b0}};
      state_d = ST_IDLE;
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (pause) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_s) begin
            pre_d = {PRE_W{1'b0}};
            if (cnt_q != {WIDTH{1'b0}}) begin
              cnt_d = cnt_q - WIDTH'(1'b1);
            end else if (auto_reload) begin
              cnt_d = rld_q;
              tc_d  = 1'b1;
            end else begin
              tc_d    = 1'b1;
              state_d = ST_EXPIRED;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1'b1);
          end
        end
        ST_IDLE, ST_PAUSED: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_EXPIRED: begin
          if (start) begin
            cnt_d   = rld_q;
            pre_d   = {PRE_W{1'b0}};
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {WIDTH{1'b0}};
      rld_q   <= {WIDTH{1'b0}};
      pre_q   <= {PRE_W{1'b0}};
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign Q       = cnt_q;
  assign tc      = tc_q;
  assign busy    = (state_q == ST_RUN);
  assign expired = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer_n.sv
// Directed bench for countdown_timer_n: a 4-bit/4-bit instance for the
// control sequences and an 8-bit/1-bit instance for full-range periods.
module tb_countdown_timer_n;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, auto_reload;
  logic [3:0] D, div;
  logic [3:0] Q;
  logic       tc, busy, expired;

  logic       load2, start2, pause2, auto2;
  logic [7:0] D2;
  logic [0:0] div2;
  logic [7:0] Q2;
  logic       tc2, busy2, expired2;

  int passed = 0;
  int total  = 0;
  int n;

  countdown_timer_n #(.WIDTH(4), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .D(D), .start(start), .pause(pause),
    .auto_reload(auto_reload), .div(div), .Q(Q), .tc(tc), .busy(busy),
    .expired(expired)
  );

  countdown_timer_n #(.WIDTH(8), .PRE_W(1)) dut8 (
    .clk(clk), .rst(rst), .load(load2), .D(D2), .start(start2), .pause(pause2),
    .auto_reload(auto2), .div(div2), .Q(Q2), .tc(tc2), .busy(busy2),
    .expired(expired2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    load2 = 1'b0; start2 = 1'b0; pause2 = 1'b0; auto2 = 1'b0;
    D2 = 8'd0; div2 = 1'b0;

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load = 1'($urandom); start = 1'($urandom); pause = 1'($urandom);
      auto_reload = 1'($urandom); D = 4'($urandom); div = 4'($urandom);
      step();
    end
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_expired", 32'(expired), 32'd0);
    chk("rst_q8", 32'(Q2), 32'd0);

    rst = 1'b0; load = 1'b0; pause = 1'b0; auto_reload = 1'b0; div = 4'd0;
    D = 4'd0; start = 1'b1;
    step();
    chk("rst_start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    chk("rst_first_tick_tc", 32'(tc), 32'd1);
    chk("rst_first_tick_exp", 32'(expired), 32'd1);
    step();
    chk("rst_tc_drop", 32'(tc), 32'd0);

    // Auto-reload, div=0
    load = 1'b1; D = 4'd3; auto_reload = 1'b1;
    step();
    chk("ar_load_q", 32'(Q), 32'd3);
    chk("ar_load_busy", 32'(busy), 32'd0);
    chk("ar_load_exp", 32'(expired), 32'd0);
    load = 1'b0; start = 1'b1;
    step();
    chk("ar_start_busy", 32'(busy), 32'd1);
    chk("ar_start_q", 32'(Q), 32'd3);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int e;
      e = ((2 - i) % 4 + 4) % 4;
      step();
      chk("ar_q", 32'(Q), 32'(e));
      chk("ar_tc", 32'(tc), (e == 3) ? 32'd1 : 32'd0);
      chk("ar_busy", 32'(busy), 32'd1);
    end

    // One-shot with div=2
    load = 1'b1; D = 4'd2; auto_reload = 1'b0; div = 4'd2;
    step();
    load = 1'b0; start = 1'b1;
    step();
    chk("os_start_q", 32'(Q), 32'd2);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("os_q", 32'(Q), 32'(2 - (i + 1) / 3));
      chk("os_tc", 32'(tc), 32'd0);
    end
    step();
    chk("os_exp_tc", 32'(tc), 32'd1);
    chk("os_exp_expired", 32'(expired), 32'd1);
    chk("os_exp_busy", 32'(busy), 32'd0);
    chk("os_exp_q", 32'(Q), 32'd0);
    step();
    chk("os_tc_drop", 32'(tc), 32'd0);
    chk("os_hold_q", 32'(Q), 32'd0);
    chk("os_hold_expired", 32'(expired), 32'd1);
    start = 1'b1;
    step();
    chk("os_restart_q", 32'(Q), 32'd2);
    chk("os_restart_busy", 32'(busy), 32'd1);
    chk("os_restart_expired", 32'(expired), 32'd0);
    start = 1'b0;

    // Pause/resume mid-prescale, D=5 div=3
    load = 1'b1; D = 4'd5; div = 4'd3;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pr_before_q", 32'(Q), 32'd4);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pr_frozen_q", 32'(Q), 32'd4);
    end
    chk("pr_paused_busy", 32'(busy), 32'd0);
    pause = 1'b0; start = 1'b1;
    step();
    chk("pr_resume_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    chk("pr_resume1_q", 32'(Q), 32'd4);
    step();
    chk("pr_resume2_q", 32'(Q), 32'd3);

    // Priority: load beats start and pause
    load = 1'b1; start = 1'b1; pause = 1'b1; D = 4'd7;
    step();
    chk("pri_q", 32'(Q), 32'd7);
    chk("pri_busy", 32'(busy), 32'd0);
    chk("pri_expired", 32'(expired), 32'd0);
    start = 1'b0; pause = 1'b0;
    D = 4'd0; div = 4'd0; auto_reload = 1'b1;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; load = 1'b1; D = 4'd9;
    step();
    chk("pri_load_tick_tc", 32'(tc), 32'd0);
    chk("pri_load_tick_q", 32'(Q), 32'd9);
    load = 1'b0;

    // Full-range period on the 8-bit instance
    load2 = 1'b1; D2 = 8'd255; div2 = 1'b1; auto2 = 1'b1;
    step();
    load2 = 1'b0; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 1; i <= 600; i++) begin
        step();
        if (tc2) begin
          n = i;
          break;
        end
      end
      chk("w8_period", 32'(n), 32'd512);
      chk("w8_reload_q", 32'(Q2), 32'd255);
    end
    step();
    chk("w8_mid_prescale_q", 32'(Q2), 32'd255);
    div2 = 1'b0;
    step();
    chk("w8_div_drop_q", 32'(Q2), 32'd254);
    step();
    chk("w8_div0_q", 32'(Q2), 32'd253);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer_n.md
# countdown_timer_n

Parametrised, programmable countdown timer, the next generation of the fixed 4-bit self-reloading countdown circuit. It adds a configurable counter width, a clock prescaler, explicit load/start/pause control, one-shot or auto-reload mode, and a registered terminal-count pulse. It sits beside the other circuit blocks as a general timebase and delay generator for sequencing logic.

## Interface
- WIDTH, 4: counter and reload-register width in bits (≥1).
- PRE_W, 4: prescaler width in bits (≥1).

- clk  in  1  rising-edge clock, only clock in the block.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture D into reload register R and into Q.
- D  in  WIDTH  reload value.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- auto_reload  in  1  1 = reload R on expiry and keep running; 0 = one-shot.
- div  in  PRE_W  prescale divisor; one tick every div+1 cycles.
- Q  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, one cycle wide.
- busy  out  1  high while in RUN.
- expired  out  1  high while in EXPIRED.

## Operation
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: counting suspended.
  - EXPIRED: one-shot has finished.
- Priority per cycle: rst > load > pause > start.
- rst:
  - Q=0, R=0, prescaler P=0, tc=0, state IDLE.
  - busy=0 and expired=0.
- load, from any state: R←D, Q←D, P←0, state→IDLE.
  - start and pause are ignored in the same cycle.
- pause in RUN: state→PAUSED. Q and P hold.
  - pause in any other state has no effect.
- start:
  - In IDLE or PAUSED: state→RUN. Q and P are kept, so a resume continues mid-prescale.
  - In EXPIRED: Q←R, P←0, state→RUN (restart).
  - In RUN: no effect.
- Prescaler, RUN only:
  - tick = (P ≥ div).
  - On tick, P←0; otherwise P←P+1.
  - Using ≥ makes a reduced div take effect without overrun.
  - div is sampled live every cycle.
- On tick in RUN:
  - Q≠0: Q←Q−1.
  - Q=0 and auto_reload=1: Q←R, tc←1, stay in RUN.
  - Q=0 and auto_reload=0: Q stays 0, tc←1, state→EXPIRED.
- Q never wraps below 0. The zero case is always handled by reload or stop.
- Starting with Q=0 is legal: the first tick expires.
- R=0 with auto_reload=1 gives tc on every tick.
- auto_reload is sampled only at the expiry tick. Changing it mid-count is legal.
- busy = (state==RUN); expired = (state==EXPIRED). Both are decoded from the state register.

## Timing
- All outputs are registered or decoded from registers. There are no combinational input-to-output paths.
- Reset values: Q=0, tc=0, busy=0, expired=0.
- load asserted at edge k: Q=D visible after edge k.
- start at edge k: busy=1 after edge k.
  - With div=0, the first decrement happens at edge k+1.
- Period from start to first tc:
  - (Q+1)·(div+1) cycles, counting from the edge after start, with P=0.
  - Auto-reload period: (R+1)·(div+1) cycles.
- tc:
  - High for exactly the one cycle after the expiry edge.
  - Coincides with Q showing R (auto-reload) or expired=1 (one-shot).
  - Low again the following cycle unless the next tick also expires (R=0, div=0 gives tc high continuously).
- load or rst on the same edge as an expiry tick: load/rst wins and tc stays 0.
- pause on the same edge as a tick: the tick is discarded and Q is unchanged.

## Test plan
- Reset: hold rst 2 cycles with random inputs → Q=0, tc=0, busy=0, expired=0; R=0 confirmed by a following start, which gives tc after 1 tick.
- Auto-reload, WIDTH=4, div=0: load D=3, start, auto_reload=1 → Q sequence 3,2,1,0,3,2,… with tc high on each cycle where Q returns to 3 (every 4 cycles) and busy held at 1.
- One-shot with prescaler, div=2: load D=2, start, auto_reload=0 → Q steps every 3 cycles (2,2,2,1,1,1,0,0,0), then tc for one cycle, expired=1, busy=0, Q held at 0; a later start reloads Q=2 and resumes.
- Pause/resume: D=5, div=3; pause after Q=4 and P=2, hold 10 cycles; then start → Q and P frozen during the pause; the next decrement occurs 2 cycles after resume (P 2→3 tick), not 4.
- Priority: assert load (D=7), start and pause together mid-RUN → Q=7, state IDLE, busy=0; assert load on the expiry-tick edge → tc stays 0.
- Edge widths, WIDTH=8, PRE_W=1: load D=255, div=1, auto_reload=1 → tc every 512 cycles with no wrap; lowering div 1→0 mid-prescale gives an immediate tick and no skipped count.
